// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - two-master round-robin arbiter for the 8-bit wishbone register bus
module wb_arbiter #(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int TIMEOUT = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_stb,
    input  logic [AW-1:0] m0_adr,
    input  logic          m0_we,
    input  logic [DW-1:0] m0_dat,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdat,
    input  logic          m1_stb,
    input  logic [AW-1:0] m1_adr,
    input  logic          m1_we,
    input  logic [DW-1:0] m1_dat,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdat,
    output logic          s_stb,
    output logic [AW-1:0] s_adr,
    output logic          s_we,
    output logic [DW-1:0] s_dat,
    input  logic          s_ack,
    input  logic [DW-1:0] s_rdat,
    output logic          owner,
    output logic          busy,
    output logic          tmo
);

    localparam int WW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t        state, state_n;
    logic          owner_n;
    logic          prio, prio_n;
    logic [WW-1:0] wdog, wdog_n;
    logic          tmo_n;
    logic          owner_stb;
    logic          grant;

    assign owner_stb = owner ? m1_stb : m0_stb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            owner <= 1'b0;
            prio  <= 1'b0;
            wdog  <= '0;
            tmo   <= 1'b0;
        end else begin
            state <= state_n;
            owner <= owner_n;
            prio  <= prio_n;
            wdog  <= wdog_n;
            tmo   <= tmo_n;
        end
    end

    always_comb begin
        state_n = state;
        owner_n = owner;
        prio_n  = prio;
        wdog_n  = wdog;
        tmo_n   = 1'b0;
        case (state)
            IDLE: begin
                wdog_n = '0;
                if (m0_stb || m1_stb) begin
                    state_n = BUSY;
                    owner_n = (m0_stb && m1_stb) ? prio : m1_stb;
                end
            end
            BUSY: begin
                wdog_n = wdog + WW'(1);
                // ack outranks a same-cycle stb drop so the completed transfer is not lost
                if (s_ack) begin
                    prio_n  = ~owner;
                    state_n = GAP;
                end else if (!owner_stb) begin
                    prio_n  = ~owner;
                    state_n = IDLE;
                end else if (wdog == WW'(TIMEOUT - 1)) begin
                    tmo_n   = 1'b1;
                    prio_n  = ~owner;
                    state_n = GAP;
                end
            end
            GAP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // rst gates the muxes so the slave side drops the instant reset rises
    assign grant   = (state == BUSY) && !rst;
    assign busy    = (state == BUSY);
    assign s_stb   = grant & owner_stb;
    assign s_adr   = grant ? (owner ? m1_adr : m0_adr) : '0;
    assign s_we    = grant & (owner ? m1_we : m0_we);
    assign s_dat   = grant ? (owner ? m1_dat : m0_dat) : '0;
    assign m0_ack  = grant & ~owner & s_ack;
    assign m1_ack  = grant & owner & s_ack;
    assign m0_rdat = (grant && !owner) ? s_rdat : '0;
    assign m1_rdat = (grant && owner) ? s_rdat : '0;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking bench for wb_arbiter with a transaction-level reference model
module tb_wb_arbiter;

    localparam int TIMEOUT = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       m0_stb, m0_we, m0_ack;
    logic [7:0] m0_adr, m0_dat, m0_rdat;
    logic       m1_stb, m1_we, m1_ack;
    logic [7:0] m1_adr, m1_dat, m1_rdat;
    logic       s_stb, s_we, s_ack;
    logic [7:0] s_adr, s_dat, s_rdat;
    logic       owner, busy, tmo;

    int n_cmp = 0;
    int n_bad = 0;

    wb_arbiter #(.AW(8), .DW(8), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .m0_stb(m0_stb), .m0_adr(m0_adr), .m0_we(m0_we), .m0_dat(m0_dat),
        .m0_ack(m0_ack), .m0_rdat(m0_rdat),
        .m1_stb(m1_stb), .m1_adr(m1_adr), .m1_we(m1_we), .m1_dat(m1_dat),
        .m1_ack(m1_ack), .m1_rdat(m1_rdat),
        .s_stb(s_stb), .s_adr(s_adr), .s_we(s_we), .s_dat(s_dat),
        .s_ack(s_ack), .s_rdat(s_rdat),
        .owner(owner), .busy(busy), .tmo(tmo)
    );

    always #5 clk = ~clk;

    // reference model: holder is the master owning the bus (-1 when free),
    // held counts bus cycles of the current tenure starting at 1
    int holder, held, last, pref;
    bit cooling, tmo_m, seen0, seen1;

    task automatic model_reset();
        holder = -1; held = 0; last = 0; pref = 0;
        cooling = 0; tmo_m = 0; seen0 = 0; seen1 = 0;
    endtask

    task automatic model_step();
        bit own_stb;
        if (rst) begin
            model_reset();
            return;
        end
        seen0 = (holder == 0) && s_ack;
        seen1 = (holder == 1) && s_ack;
        tmo_m = 0;
        if (holder >= 0) begin
            own_stb = (holder == 1) ? m1_stb : m0_stb;
            if (s_ack) begin
                pref = 1 - holder; holder = -1; cooling = 1;
            end else if (!own_stb) begin
                pref = 1 - holder; holder = -1;
            end else if (held == TIMEOUT) begin
                pref = 1 - holder; holder = -1; cooling = 1; tmo_m = 1;
            end else begin
                held++;
            end
        end else if (cooling) begin
            cooling = 0;
        end else if (m0_stb || m1_stb) begin
            holder = (m0_stb && m1_stb) ? pref : (m1_stb ? 1 : 0);
            last = holder;
            held = 1;
        end
    endtask

    function automatic logic [63:0] model_vec();
        bit         on, h1;
        logic       e_stb, e_we, a0, a1;
        logic [7:0] e_adr, e_dat, r0, r1;
        on    = (holder >= 0);
        h1    = (holder == 1);
        e_stb = on && (h1 ? m1_stb : m0_stb);
        e_adr = on ? (h1 ? m1_adr : m0_adr) : 8'h00;
        e_we  = on && (h1 ? m1_we : m0_we);
        e_dat = on ? (h1 ? m1_dat : m0_dat) : 8'h00;
        a0    = on && !h1 && s_ack;
        a1    = on && h1 && s_ack;
        r0    = (on && !h1) ? s_rdat : 8'h00;
        r1    = (on && h1) ? s_rdat : 8'h00;
        return {25'd0, e_stb, e_adr, e_we, e_dat, a0, r0, a1, r1,
                (last == 1), on, tmo_m};
    endfunction

    function automatic logic [63:0] dut_vec();
        return {25'd0, s_stb, s_adr, s_we, s_dat, m0_ack, m0_rdat, m1_ack, m1_rdat,
                owner, busy, tmo};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic sample();
        #4;
        chk("cycle", dut_vec(), model_vec());
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clear_inputs();
        m0_stb = 0; m0_adr = 0; m0_we = 0; m0_dat = 0;
        m1_stb = 0; m1_adr = 0; m1_we = 0; m1_dat = 0;
        s_ack = 0; s_rdat = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    int busy_cnt, tmo_cnt, ack_cnt;
    bit found;

    initial begin
        clear_inputs();
        rst = 1;
        model_reset();
        #1;
        chk("reset_state", dut_vec(), 64'd0);
        @(posedge clk);
        #1;
        rst = 0;

        // single read from m0
        m0_stb = 1; m0_adr = 8'h12; m0_we = 0;
        sample(); tick();
        sample();
        chk("read_sstb", {63'd0, s_stb}, 64'd1);
        chk("read_sadr", {56'd0, s_adr}, 64'h12);
        tick();
        sample(); tick();
        s_ack = 1; s_rdat = 8'hA5;
        sample();
        chk("read_ack", {55'd0, m0_ack, m0_rdat}, {55'd0, 1'b1, 8'hA5});
        chk("read_m1ack", {63'd0, m1_ack}, 64'd0);
        tick();
        s_ack = 0; s_rdat = 0;
        sample();
        chk("read_gap", {62'd0, busy, s_stb}, 64'd0);
        tick();
        m0_stb = 0;
        sample(); tick();

        // contention from reset: grants alternate m0, m1, m0, m1
        do_reset();
        m0_stb = 1; m0_adr = 8'h10;
        m1_stb = 1; m1_adr = 8'h20;
        for (int k = 0; k < 4; k++) begin
            sample(); tick();
            s_ack = 1; s_rdat = 8'(k);
            sample();
            chk("cont_owner", {63'd0, owner}, 64'(k % 2));
            chk("cont_sadr", {56'd0, s_adr}, (k % 2 == 1) ? 64'h20 : 64'h10);
            tick();
            s_ack = 0;
            sample(); tick();
        end
        clear_inputs();
        sample(); tick();

        // m1 write with m0 arriving mid-transfer
        m1_stb = 1; m1_we = 1; m1_adr = 8'h40; m1_dat = 8'h3C;
        sample(); tick();
        sample();
        chk("write_data", {54'd0, s_stb, s_we, s_dat}, {54'd0, 1'b1, 1'b1, 8'h3C});
        tick();
        m0_stb = 1; m0_adr = 8'h55; m0_we = 0;
        sample(); tick();
        s_ack = 1;
        sample();
        chk("write_acks", {62'd0, m1_ack, m0_ack}, 64'b10);
        tick();
        s_ack = 0; m1_stb = 0; m1_we = 0;
        sample();
        chk("write_gap", {62'd0, owner, busy}, 64'b10);
        tick();
        sample(); tick();
        sample();
        chk("m0_after_gap", {62'd0, owner, busy}, 64'b01);

        // m0 abandons after 16 cycles with m1 pending
        m1_stb = 1; m1_adr = 8'h77;
        tick();
        for (int i = 2; i <= 16; i++) begin
            sample(); tick();
        end
        m0_stb = 0;
        sample(); tick();
        sample();
        chk("abandon_idle", {61'd0, busy, tmo, m0_ack}, 64'd0);
        tick();
        sample();
        chk("abandon_m1", {62'd0, owner, busy}, 64'b11);

        // watchdog: m1 holds stb with no ack
        busy_cnt = 1; tmo_cnt = 0; ack_cnt = 0; found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick(); sample();
            ack_cnt += int'(m1_ack);
            if (tmo) begin
                found = 1;
                tmo_cnt++;
                chk("wdog_gap_sstb", {63'd0, s_stb}, 64'd0);
            end else if (busy) begin
                busy_cnt++;
            end
        end
        chk("wdog_busy_cycles", 64'(busy_cnt), 64'(TIMEOUT));
        m1_stb = 0;
        for (int i = 0; i < 3; i++) begin
            tick(); sample();
            tmo_cnt += int'(tmo);
        end
        chk("wdog_tmo_once", 64'(tmo_cnt), 64'd1);
        chk("wdog_no_ack", 64'(ack_cnt), 64'd0);

        // asynchronous reset in the middle of an m1 transfer
        m1_stb = 1; m1_adr = 8'h9E;
        tick(); sample();
        tick(); sample();
        chk("pre_reset_m1", {61'd0, s_stb, owner, busy}, 64'b111);
        #1;
        rst = 1;
        model_reset();
        #1;
        chk("async_reset", {61'd0, s_stb, busy, owner}, 64'd0);
        @(posedge clk);
        model_step();
        #1;
        sample(); tick();
        rst = 0;
        m0_stb = 1; m0_adr = 8'h01;
        sample(); tick();
        sample();
        chk("post_reset_m0", {62'd0, owner, busy}, 64'b01);
        s_ack = 1;
        tick();
        s_ack = 0; m0_stb = 0; m1_stb = 0;
        sample(); tick();

        // randomized masters and slave against the model
        for (int n = 0; n < 1500; n++) begin
            if (m0_stb) begin
                if (seen0 || $urandom_range(0, 39) == 0) m0_stb = 0;
            end else if ($urandom_range(0, 2) == 0) begin
                m0_stb = 1; m0_adr = 8'($urandom); m0_we = 1'($urandom); m0_dat = 8'($urandom);
            end
            if (m1_stb) begin
                if (seen1 || $urandom_range(0, 39) == 0) m1_stb = 0;
            end else if ($urandom_range(0, 2) == 0) begin
                m1_stb = 1; m1_adr = 8'($urandom); m1_we = 1'($urandom); m1_dat = 8'($urandom);
            end
            s_ack  = ($urandom_range(0, 7) == 0);
            s_rdat = 8'($urandom);
            sample(); tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
